// File: rtl/user_id_pkg.sv
// Shared types and constants for the user-ID nibble-load interface.
package user_id_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int ID_W          = 16;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_GAP_CYC   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOAD  = 2'd2,
        GAP   = 2'd3
    } sender_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cycle_down_counter.sv
// Loadable down-counter with a zero flag; used to time the SETUP and GAP phases.
module cycle_down_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Reload has priority over decrement; decrement saturates at zero so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/user_id_sender.sv
// Replays a captured user ID as framed nibbles (MSB first) toward the user_id entry block.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for start; id_nibble holds its last value
//   SETUP | nibble presented, held SETUP_CYC cycles before its strobe
//   LOAD  | load_out high for this single cycle
//   GAP   | nibble held GAP_CYC cycles after the strobe
module user_id_sender
    import user_id_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int NIBBLES   = 4,
    localparam int ID_BITS  = NIBBLE_W * NIBBLES,
    localparam int IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ID_BITS-1:0]  id_in,
    output logic                ready,
    output logic [NIBBLE_W-1:0] id_nibble,
    output logic                load_out,
    output logic [IDX_W-1:0]    nib_idx,
    output logic                done
);

    localparam int CNT_W = $clog2(max_int(SETUP_CYC, GAP_CYC) + 1);

    sender_state_t      state;
    logic [ID_BITS-1:0] sreg;
    logic               cnt_load;
    logic [CNT_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               last_nib;

    assign last_nib = (nib_idx == IDX_W'(NIBBLES - 1));

    // The counter is preloaded with (duration - 1) on each state entry, so the
    // state is left on the cycle where the counter reads zero.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(SETUP_CYC - 1);
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(GAP_CYC - 1);
            end
            GAP: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = last_nib ? '0 : CNT_W'(SETUP_CYC - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    cycle_down_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer with registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            sreg      <= '0;
            id_nibble <= '0;
            nib_idx   <= '0;
            load_out  <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
        end else begin
            load_out <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg      <= id_in;
                        id_nibble <= id_in[ID_BITS-1 -: NIBBLE_W];
                        nib_idx   <= '0;
                        ready     <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        load_out <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    state <= GAP;
                end
                GAP: begin
                    if (cnt_zero) begin
                        if (last_nib) begin
                            done  <= 1'b1;
                            ready <= 1'b1;
                            state <= IDLE;
                        end else begin
                            sreg      <= sreg << NIBBLE_W;
                            id_nibble <= sreg[ID_BITS-1-NIBBLE_W -: NIBBLE_W];
                            nib_idx   <= nib_idx + IDX_W'(1);
                            state     <= SETUP;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_user_id_sender.sv
// Directed bench for user_id_sender: default and short-timing instances plus a loopback receiver model.
module tb_user_id_sender;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] id_in;
    logic        ready, load_out, done;
    logic [3:0]  id_nibble;
    logic [1:0]  nib_idx;

    logic        s_start;
    logic [15:0] s_id;
    logic        s_ready, s_load, s_done;
    logic [3:0]  s_nib;
    logic [1:0]  s_idx;

    logic [15:0] rx_id;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    user_id_sender dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .id_in     (id_in),
        .ready     (ready),
        .id_nibble (id_nibble),
        .load_out  (load_out),
        .nib_idx   (nib_idx),
        .done      (done)
    );

    user_id_sender #(.SETUP_CYC(1), .GAP_CYC(1), .NIBBLES(4)) dut_short (
        .clk       (clk),
        .rst       (rst),
        .start     (s_start),
        .id_in     (s_id),
        .ready     (s_ready),
        .id_nibble (s_nib),
        .load_out  (s_load),
        .nib_idx   (s_idx),
        .done      (s_done)
    );

    // Stand-in for the user_id receiver: shifts in a nibble on every load strobe.
    always_ff @(posedge clk) begin
        if (!rst) rx_id <= '0;
        else if (load_out) rx_id <= {rx_id[11:0], id_nibble};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; id_in = '0; s_start = 1'b0; s_id = '0;
        tick(); tick();
        vectors++;
        if ({ready, id_nibble, load_out, nib_idx, done} !== {1'b1, 4'h0, 1'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset got ready=%b nib=%h load=%b idx=%0d done=%b exp 1 0 0 0 0",
                     ready, id_nibble, load_out, nib_idx, done);
        end
        vectors++;
        if ({s_ready, s_nib, s_load, s_idx, s_done} !== {1'b1, 4'h0, 1'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_short got ready=%b nib=%h load=%b idx=%0d done=%b exp 1 0 0 0 0",
                     s_ready, s_nib, s_load, s_idx, s_done);
        end
        rst = 1'b1;
        tick();
    endtask

    // Full cycle-by-cycle check of one default-timing sequence; optional ignored start at k=7.
    task automatic check_default_seq(input string name, input logic [15:0] id, input bit poke);
        logic [15:0] cap;
        int          strobes;
        int          n;
        logic [3:0]  exp_nib;
        logic        exp_load, exp_last;
        cap = '0; strobes = 0;
        start = 1'b1; id_in = id;
        tick();
        start = 1'b0; id_in = 16'h5555;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            n        = (k < 20) ? (k / 5) : 3;
            exp_nib  = id[15 - 4*n -: 4];
            exp_load = (k < 20) && ((k % 5) == 2);
            exp_last = (k == 20);
            vectors++;
            if ({load_out, id_nibble, nib_idx, done, ready} !==
                {exp_load, exp_nib, 2'(n), exp_last, exp_last}) begin
                miscompares++;
                $display("FAIL %s k=%0d got load=%b nib=%h idx=%0d done=%b ready=%b exp load=%b nib=%h idx=%0d done=%b ready=%b",
                         name, k, load_out, id_nibble, nib_idx, done, ready,
                         exp_load, exp_nib, n, exp_last, exp_last);
            end
            if (load_out === 1'b1) begin
                cap = {cap[11:0], id_nibble};
                strobes++;
            end
            if (poke && k == 7) begin start = 1'b1; id_in = 16'h1234; end
            if (poke && k == 8) begin start = 1'b0; id_in = 16'h5555; end
        end
        vectors++;
        if (cap !== id || strobes != 4) begin
            miscompares++;
            $display("FAIL %s_strobes got %h/%0d exp %h/4", name, cap, strobes, id);
        end
        tick();
    endtask

    task automatic test_basic();
        check_default_seq("basic", 16'hABC1, 1'b0);
    endtask

    task automatic test_ignored_start();
        check_default_seq("ignored_start", 16'hABC1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int extra;
        extra = 0;
        start = 1'b1; id_in = 16'hABC1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({ready, id_nibble, load_out, nib_idx, done} !== {1'b1, 4'h0, 1'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid got ready=%b nib=%h load=%b idx=%0d done=%b exp 1 0 0 0 0",
                     ready, id_nibble, load_out, nib_idx, done);
        end
        tick();
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (load_out !== 1'b0 || ready !== 1'b1 || done !== 1'b0) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet got %0d bad cycles exp 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] cap;
        int          strobes;
        int          idx_bad;
        cap = '0; strobes = 0; idx_bad = 0;
        start = 1'b1; id_in = 16'h5A3C;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (load_out === 1'b1) begin cap = {cap[11:0], id_nibble}; strobes++; end
            if (k == 18) begin start = 1'b1; id_in = 16'h0F0F; end
        end
        vectors++;
        if ({done, ready, cap} !== {1'b1, 1'b1, 16'h5A3C} || strobes != 4) begin
            miscompares++;
            $display("FAIL b2b_first got done=%b ready=%b cap=%h n=%0d exp 1 1 5a3c 4",
                     done, ready, cap, strobes);
        end
        tick();
        start = 1'b0; id_in = 16'hFFFF;
        vectors++;
        if ({ready, done, id_nibble, nib_idx} !== {1'b0, 1'b0, 4'h0, 2'd0}) begin
            miscompares++;
            $display("FAIL b2b_restart got ready=%b done=%b nib=%h idx=%0d exp 0 0 0 0",
                     ready, done, id_nibble, nib_idx);
        end
        cap = '0; strobes = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (load_out === 1'b1) begin
                if (nib_idx !== 2'(strobes)) idx_bad++;
                cap = {cap[11:0], id_nibble};
                strobes++;
            end
            if (k == 19) begin
                vectors++;
                if (done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_early_done got %b exp 0", done);
                end
            end
        end
        vectors++;
        if ({done, cap} !== {1'b1, 16'h0F0F} || strobes != 4 || idx_bad != 0) begin
            miscompares++;
            $display("FAIL b2b_second got done=%b cap=%h n=%0d idxbad=%0d exp 1 0f0f 4 0",
                     done, cap, strobes, idx_bad);
        end
        tick();
    endtask

    task automatic test_loopback();
        bit seen;
        seen = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1; id_in = 16'hABC1;
        tick();
        start = 1'b0; id_in = 16'h0000;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL loopback_timeout got no done within 40 cycles exp done");
        end
        vectors++;
        if (rx_id !== 16'hABC1) begin
            miscompares++;
            $display("FAIL loopback got %h exp abc1", rx_id);
        end
        tick();
    endtask

    task automatic test_short_timing();
        logic [15:0] id;
        int          n;
        logic [3:0]  exp_nib;
        logic        exp_load, exp_last;
        id = 16'h7E29;
        s_start = 1'b1; s_id = id;
        tick();
        s_start = 1'b0; s_id = 16'h0000;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            n        = (k < 12) ? (k / 3) : 3;
            exp_nib  = id[15 - 4*n -: 4];
            exp_load = (k < 12) && ((k % 3) == 1);
            exp_last = (k == 12);
            vectors++;
            if ({s_load, s_nib, s_idx, s_done, s_ready} !==
                {exp_load, exp_nib, 2'(n), exp_last, exp_last}) begin
                miscompares++;
                $display("FAIL short k=%0d got load=%b nib=%h idx=%0d done=%b ready=%b exp load=%b nib=%h idx=%0d done=%b ready=%b",
                         k, s_load, s_nib, s_idx, s_done, s_ready,
                         exp_load, exp_nib, n, exp_last, exp_last);
            end
        end
        tick();
        vectors++;
        if (s_done !== 1'b0) begin
            miscompares++;
            $display("FAIL short_done_pulse got %b exp 0", s_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_loopback();
        test_short_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
